// File: rtl/sm_alu_pkg.sv
// sm_alu_pkg: shared types and sign-magnitude helpers for the ALU scheduler
package sm_alu_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_t;
  // Invert the sign bit of a w-bit sign-magnitude value held in the low bits
  function automatic logic [63:0] flip_sign(input logic [63:0] x, input int w);
    return x ^ (64'd1 << (w - 1));
  endfunction
  // Turn a negative zero into positive zero, leave everything else alone
  function automatic logic [63:0] norm_zero(input logic [63:0] x, input int w);
    return ((x & ~(64'd1 << (w - 1))) == 64'd0) ? 64'd0 : x;
  endfunction
endpackage

// File: rtl/sm_alu_sched_rr_arb.sv
// rr_arb: round-robin one-hot arbiter searching upward from the last grant
module rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  input  logic            i_en,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx
);
  logic [IDW-1:0] w_k;
  // Scan farthest-first so the requester nearest after the pointer wins last
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_k   = '0;
    for (int i = NREQ; i >= 1; i--) begin
      w_k = IDW'((int'(i_ptr) + i) % NREQ);
      if (i_en && i_req[w_k]) begin
        o_gnt      = '0;
        o_gnt[w_k] = 1'b1;
        o_idx      = w_k;
      end
    end
  end
endmodule

// File: rtl/subtract.sv
// subtract: combinational sign-magnitude A-B with magnitude overflow flag
module subtract #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_out,
  output logic         o_carry
);
  logic         w_sa;
  logic         w_sb;
  logic [N-2:0] w_ma;
  logic [N-2:0] w_mb;
  logic [N-1:0] w_sum;
  assign w_sa  = i_a[N-1];
  assign w_sb  = i_b[N-1];
  assign w_ma  = i_a[N-2:0];
  assign w_mb  = i_b[N-2:0];
  assign w_sum = {1'b0, w_ma} + {1'b0, w_mb};
  // Opposite signs add magnitudes; equal signs subtract the smaller from the larger
  always_comb begin
    o_out   = (w_sa != w_sb) ? {w_sa, w_sum[N-2:0]} :
              (w_ma > w_mb)  ? {w_sa, w_ma - w_mb} : {~w_sa, w_mb - w_ma};
    o_carry = (w_sa != w_sb) & w_sum[N-1];
  end
endmodule

// File: rtl/sm_alu_sched.sv
// sm_alu_sched: round-robin scheduler sharing one sign-magnitude add/sub datapath
module sm_alu_sched
  import sm_alu_pkg::*;
#(
  parameter int N    = 8,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NREQ-1:0]   i_req_valid,
  output logic [NREQ-1:0]   o_req_ready,
  input  logic [NREQ*N-1:0] i_req_a,
  input  logic [NREQ*N-1:0] i_req_b,
  input  logic [NREQ-1:0]   i_req_op,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [IDW-1:0]    o_rsp_id,
  output logic [N-1:0]      o_rsp_out,
  output logic              o_rsp_carry,
  output logic              o_busy
);
  state_t         r_state;
  state_t         w_next;
  logic [IDW-1:0] r_ptr;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  op_t            r_op;
  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0] w_idx;
  logic           w_acc;
  logic [N-1:0]   w_a;
  logic [N-1:0]   w_b_in;
  logic           w_op;
  logic [N-1:0]   w_dp_b;
  logic [N-1:0]   w_dp_out;
  logic           w_dp_carry;

  rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .i_req (i_req_valid),
    .i_ptr (r_ptr),
    .i_en  ((r_state == IDLE) & i_rst),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  assign w_acc       = |w_gnt;
  assign o_req_ready = w_gnt;
  assign o_rsp_valid = (r_state == RESP);
  assign o_busy      = (r_state != IDLE);
  assign w_op        = |(w_gnt & i_req_op);
  assign w_dp_b      = (r_op == OP_ADD) ? N'(flip_sign(64'(r_b), N)) : r_b;

  subtract #(.N(N)) u_sub (
    .i_a     (r_a),
    .i_b     (w_dp_b),
    .o_out   (w_dp_out),
    .o_carry (w_dp_carry)
  );

  // Select the granted requester's operands
  always_comb begin
    w_a    = '0;
    w_b_in = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_gnt[k]) begin
        w_a    = i_req_a[k*N +: N];
        w_b_in = i_req_b[k*N +: N];
      end
    end
  end

  // Next-state: accept -> one execute cycle -> hold response until consumed
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (w_acc ? EXEC : IDLE) :
             (r_state == EXEC) ? RESP :
             (i_rsp_ready ? IDLE : RESP);
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Operand latch on grant, result capture in EXEC; pointer starts so req0 is first
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_ptr       <= IDW'(NREQ - 1);
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= OP_ADD;
      o_rsp_id    <= '0;
      o_rsp_out   <= '0;
      o_rsp_carry <= 1'b0;
    end else if (w_acc) begin
      r_ptr    <= w_idx;
      r_a      <= w_a;
      r_b      <= w_b_in;
      r_op     <= op_t'(w_op);
      o_rsp_id <= w_idx;
    end else if (r_state == EXEC) begin
      o_rsp_out   <= N'(norm_zero(64'(w_dp_out), N));
      o_rsp_carry <= w_dp_carry;
    end
  end
endmodule

// File: tb/tb_sm_alu_sched.sv
// tb_sm_alu_sched: directed self-checking bench for the round-robin ALU scheduler
module tb_sm_alu_sched;
  localparam int N = 8;
  localparam int NREQ = 4;
  localparam int IDW = 2;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b0;
  logic [NREQ-1:0]   i_req_valid = '0;
  logic [NREQ-1:0]   o_req_ready;
  logic [NREQ*N-1:0] i_req_a = '0;
  logic [NREQ*N-1:0] i_req_b = '0;
  logic [NREQ-1:0]   i_req_op = '0;
  logic              o_rsp_valid;
  logic              i_rsp_ready = 1'b1;
  logic [IDW-1:0]    o_rsp_id;
  logic [N-1:0]      o_rsp_out;
  logic              o_rsp_carry;
  logic              o_busy;

  int checks = 0;
  int errors = 0;

  sm_alu_sched #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_a     (i_req_a),
    .i_req_b     (i_req_b),
    .i_req_op    (i_req_op),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_id    (o_rsp_id),
    .o_rsp_out   (o_rsp_out),
    .o_rsp_carry (o_rsp_carry),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [7:0] a, input logic [7:0] b, input logic op);
    i_req_a[k*N +: N] = a;
    i_req_b[k*N +: N] = b;
    i_req_op[k] = op;
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_out, o_rsp_carry, o_busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b valid=%b id=%0d out=%h carry=%b busy=%b expected all zero",
               o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_out, o_rsp_carry, o_busy);
    end
    i_rst = 1'b1;
    tick();
  endtask

  task automatic do_op(input string name, input int k, input logic [7:0] a, input logic [7:0] b,
                       input logic op, input logic [7:0] exp_out, input logic exp_c);
    logic [NREQ-1:0] exp_gnt;
    exp_gnt = '0;
    exp_gnt[k] = 1'b1;
    i_rsp_ready = 1'b1;
    set_req(k, a, b, op);
    i_req_valid = exp_gnt;
    #1;
    checks++;
    if (o_req_ready !== exp_gnt) begin
      errors++;
      $display("FAIL %s_grant: got %b expected %b", name, o_req_ready, exp_gnt);
    end
    tick();
    i_req_valid = '0;
    checks++;
    if (o_rsp_valid !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_exec: got valid=%b busy=%b expected valid=0 busy=1", name, o_rsp_valid, o_busy);
    end
    tick();
    checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_out !== exp_out || o_rsp_carry !== exp_c || o_rsp_id !== IDW'(k)) begin
      errors++;
      $display("FAIL %s_rsp: got valid=%b out=%h carry=%b id=%0d expected valid=1 out=%h carry=%b id=%0d",
               name, o_rsp_valid, o_rsp_out, o_rsp_carry, o_rsp_id, exp_out, exp_c, k);
    end
    tick();
    checks++;
    if (o_rsp_valid !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: got valid=%b busy=%b expected 0 0", name, o_rsp_valid, o_busy);
    end
  endtask

  task automatic test_arith();
    do_op("sub_5_3", 0, 8'h05, 8'h03, 1'b1, 8'h02, 1'b0);
    do_op("add_5_m3", 2, 8'h05, 8'h83, 1'b0, 8'h02, 1'b0);
    do_op("add_m3_1", 1, 8'h83, 8'h81, 1'b0, 8'h84, 1'b0);
    do_op("sub_eq_zero", 0, 8'h05, 8'h05, 1'b1, 8'h00, 1'b0);
    do_op("add_overflow", 3, 8'h7F, 8'h01, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_gnt;
    int kk;
    i_rsp_ready = 1'b1;
    for (int k = 0; k < NREQ; k++) set_req(k, 8'(k + 1), 8'h01, 1'b1);
    i_req_valid = '1;
    #1;
    for (int c = 0; c <= 12; c++) begin
      kk = (c / 3) % NREQ;
      exp_gnt = '0;
      if (c % 3 == 0) exp_gnt[kk] = 1'b1;
      checks++;
      if (o_req_ready !== exp_gnt) begin
        errors++;
        $display("FAIL rr_grant_c%0d: got %b expected %b", c, o_req_ready, exp_gnt);
      end
      if (c % 3 == 2) begin
        checks++;
        if (o_rsp_valid !== 1'b1 || o_rsp_id !== IDW'(kk) || o_rsp_out !== 8'(kk)) begin
          errors++;
          $display("FAIL rr_rsp_c%0d: got valid=%b id=%0d out=%h expected 1 %0d %h",
                   c, o_rsp_valid, o_rsp_id, o_rsp_out, kk, 8'(kk));
        end
      end
      if (c < 12) begin
        @(posedge i_clk);
        #2;
      end
    end
    tick();
    i_req_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_backpressure();
    i_rsp_ready = 1'b0;
    set_req(2, 8'h09, 8'h04, 1'b0);
    i_req_valid = 4'b0100;
    #1;
    checks++;
    if (o_req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL bp_grant: got %b expected 0100", o_req_ready);
    end
    tick();
    i_req_valid = '0;
    tick();
    set_req(0, 8'h01, 8'h01, 1'b0);
    set_req(1, 8'h01, 8'h01, 1'b0);
    set_req(3, 8'h01, 8'h01, 1'b0);
    i_req_valid = 4'b1011;
    #1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (o_rsp_valid !== 1'b1 || o_rsp_out !== 8'h0D || o_rsp_id !== 2'd2 || o_rsp_carry !== 1'b0 ||
          o_req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold_%0d: got valid=%b out=%h id=%0d carry=%b ready=%b expected 1 0d 2 0 0000",
                 c, o_rsp_valid, o_rsp_out, o_rsp_id, o_rsp_carry, o_req_ready);
      end
      if (c < 4) begin
        @(posedge i_clk);
        #2;
      end
    end
    i_rsp_ready = 1'b1;
    tick();
    #1;
    checks++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL bp_next_grant: got valid=%b ready=%b expected 0 1000", o_rsp_valid, o_req_ready);
    end
    tick();
    i_req_valid = '0;
    tick();
    checks++;
    if (o_rsp_out !== 8'h02 || o_rsp_id !== 2'd3) begin
      errors++;
      $display("FAIL bp_next_rsp: got out=%h id=%0d expected 02 3", o_rsp_out, o_rsp_id);
    end
    tick();
  endtask

  task automatic test_reset_exec();
    i_rsp_ready = 1'b1;
    set_req(1, 8'h10, 8'h85, 1'b1);
    set_req(2, 8'h02, 8'h07, 1'b1);
    i_req_valid = 4'b0110;
    #1;
    checks++;
    if (o_req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL rst_pre_grant: got %b expected 0010", o_req_ready);
    end
    tick();
    i_rst = 1'b0;
    #1;
    checks++;
    if ({o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_out, o_rsp_carry, o_busy} !== '0) begin
      errors++;
      $display("FAIL rst_exec_outputs: got ready=%b valid=%b id=%0d out=%h carry=%b busy=%b expected all zero",
               o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_out, o_rsp_carry, o_busy);
    end
    tick();
    i_rst = 1'b1;
    #1;
    checks++;
    if (o_req_ready !== 4'b0010 || o_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_post_grant: got ready=%b valid=%b expected 0010 0", o_req_ready, o_rsp_valid);
    end
    tick();
    i_req_valid = '0;
    checks++;
    if (o_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_stale: got valid=%b expected 0", o_rsp_valid);
    end
    tick();
    checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_out !== 8'h15 || o_rsp_id !== 2'd1 || o_rsp_carry !== 1'b0) begin
      errors++;
      $display("FAIL rst_post_rsp: got valid=%b out=%h id=%0d carry=%b expected 1 15 1 0",
               o_rsp_valid, o_rsp_out, o_rsp_id, o_rsp_carry);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_arith();
    test_round_robin();
    test_backpressure();
    test_reset_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sm_alu_sched.md
Name: sm_alu_sched

Overview:
Round-robin scheduler that shares one sign-magnitude add/subtract datapath among NREQ requesters. It accepts one operation at a time over a valid/ready handshake and sequences it through the datapath. The result is returned on a single registered response channel tagged with the requester ID. It sits between the requesting control units and the team's `subtract` unit.

Parameters:
N, 8, operand/result width in sign-magnitude; MSB is the sign, N-1 bits are magnitude
NREQ, 4, number of requesters (2..8)
IDW, $clog2(NREQ), derived, response tag width

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous, active-low reset
i_req_valid  in  NREQ  per-requester request valid
o_req_ready  out  NREQ  per-requester accept strobe; one-hot or zero
i_req_a  in  NREQ*N  flattened operand A; requester k occupies [k*N +: N]
i_req_b  in  NREQ*N  flattened operand B, same packing
i_req_op  in  NREQ  per-requester op: 0 = add (A+B), 1 = sub (A-B)
o_rsp_valid  out  1  response valid
i_rsp_ready  in  1  response consumer ready
o_rsp_id  out  IDW  index of the requester that issued the op
o_rsp_out  out  N  sign-magnitude result
o_rsp_carry  out  1  magnitude overflow flag from the datapath
o_busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (i_rst low, async):
  - State = IDLE; all outputs = 0.
  - Round-robin pointer set so requester 0 has highest priority.
  - Operand and result registers cleared.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - o_req_ready is combinational and one-hot on the granted requester.
  - Grant goes to the first valid requester searching from (last_grant+1) mod NREQ upward.
  - Handshake completes in the same cycle: latch A, B, op and ID; pointer := granted index; next state EXEC.
  - If no requester is valid, stay in IDLE with o_req_ready = 0.
- EXEC (one cycle):
  - Datapath input b = latched B for sub; latched B with its sign bit inverted for add (A+B = A-(-B)).
  - Register the datapath result into o_rsp_out / o_rsp_carry.
  - Negative-zero normalisation: if the magnitude is 0, force sign = 0 (the datapath yields sign 1 for equal magnitudes).
  - Next state RESP.
- RESP:
  - o_rsp_valid = 1; o_rsp_id, o_rsp_out and o_rsp_carry held stable.
  - On i_rsp_ready = 1: o_rsp_valid drops the next cycle and state goes to IDLE.
  - o_req_ready = 0 throughout RESP.
- Timing:
  - Accept at cycle T gives o_rsp_valid at T+2.
  - Minimum spacing between accepts is 3 cycles; there is no accept in the cycle the response completes.
- Fairness and request rules:
  - The pointer updates only on a grant.
  - A requester that drops valid before being granted loses nothing.
  - Requesters must hold a/b/op stable while valid and not yet accepted.
- o_rsp_carry = 1 only when magnitude addition exceeds 2^(N-1)-1. In that case o_rsp_out magnitude holds the wrapped low bits, and the sign follows the datapath.
- Reset asserted in EXEC or RESP aborts the in-flight op; no response is issued.
- No output may contain X after reset when inputs are driven.

Decomposition:
- Package sm_alu_pkg:
  - Enum state_t {IDLE, EXEC, RESP}.
  - Enum op_t {OP_ADD = 1'b0, OP_SUB = 1'b1}.
  - Function to negate the sign bit.
  - Function to normalise negative zero.
- Sub-module rr_arb (parameter NREQ):
  - Inputs: request vector, pointer, enable.
  - Outputs: one-hot grant and grant index.
- The existing `subtract` unit is instantiated once as the shared datapath.

Test Plan:
- Reset then 0x05 sub 0x03 from req0 -> o_rsp_valid at T+2, o_rsp_out = 0x02, carry = 0, id = 0.
- Add 0x05 + 0x83 (5 + -3) from req2 -> 0x02, carry 0, id 2. Add 0x83 + 0x81 -> 0x84.
- Sub 0x05 - 0x05 -> o_rsp_out = 0x00 (not 0x80). Add 0x7F + 0x01 -> o_rsp_out = 0x00, carry = 1.
- All four requesters held valid with i_rsp_ready = 1 -> grants in order 0,1,2,3,0 with accepts spaced exactly 3 cycles; o_req_ready never has more than one bit set.
- i_rsp_ready held low for 5 cycles in RESP -> rsp outputs stable, o_req_ready = 0 throughout; one cycle after ready rises, the next grant goes to the requester after the last granted one.
- i_rst pulsed low during EXEC -> all outputs 0 immediately; after release, the first grant goes to the lowest valid index and no stale response appears.
